// File: rtl/apb_master.sv
// APB requester: turns a cmd_valid/cmd_ready handshake into APB SETUP/ACCESS transfers.
// Latency: acceptance edge to completion edge is 2 edges minimum; rsp_valid appears in the cycle after completion.
// Backpressure: cmd_ready is high only in IDLE; pready low adds wait states; responses cannot be stalled.
//
// Ports:
//   pclk, rst_n                          clock and asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/
//   cmd_addr/cmd_wdata                   command handshake and command fields
//   rsp_valid/rsp_rdata/rsp_timeout      one-cycle completion pulse, read data, abort flag
//   paddr/pwrite/psel/penable/pwdata     APB requester outputs, all registered
//   prdata/pready                        APB slave responses
module apb_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // Wide enough to hold TIMEOUT-1; one bit when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic [CNT_W-1:0]    wait_cnt_q,    wait_cnt_d;
    logic [ADDR_W-1:0]   paddr_q,       paddr_d;
    logic                pwrite_q,      pwrite_d;
    logic                psel_q,        psel_d;
    logic                penable_q,     penable_d;
    logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;          // response is a single-cycle pulse
        rsp_rdata_d   = rsp_rdata_q;   // data/status hold until the next completion
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;   // driven for reads too; slaves ignore it
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                // pready is deliberately ignored here: SETUP always lasts one cycle.
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    state_d       = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = IDLE;
                end else if (wait_cnt_q != CNT_MAX) begin
                    // Saturating so an unlimited wait (TIMEOUT=0) never wraps.
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: table of per-cycle vectors plus hand-written timeout and reset sequences.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The slave side is modelled purely by the pready/prdata values in each vector.
module tb_apb_master;

    logic       pclk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic [3:0] paddr;
    logic       pwrite;
    logic       psel;
    logic       penable;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;

    int checks = 0;
    int errors = 0;

    apb_master #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(15)) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .psel        (psel),
        .penable     (penable),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic       cv;
        logic       cw;
        logic [3:0] ca;
        logic [7:0] cd;
        logic [7:0] prd;
        logic       prdy;
        logic       e_psel;
        logic       e_pen;
        logic       e_pwr;
        logic [3:0] e_paddr;
        logic [7:0] e_pwdata;
        logic       e_rv;
        logic [7:0] e_rdata;
        logic       e_rto;
        logic       e_crdy;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic cw, input logic [3:0] ca,
                         input logic [7:0] cd, input logic [7:0] prd, input logic prdy);
        cmd_valid = cv;
        cmd_write = cw;
        cmd_addr  = ca;
        cmd_wdata = cd;
        prdata    = prd;
        pready    = prdy;
    endtask

    // Packed view {psel,penable,pwrite,paddr,pwdata,rsp_valid,rsp_rdata,rsp_timeout,cmd_ready}
    function automatic logic [31:0] outs();
        return {6'd0, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_timeout, cmd_ready};
    endfunction

    initial begin
        int pen_cnt;
        int guard;

        //        cv  cw  ca    cd     prd    rdy | psel pen pwr paddr pwdata rv rdata  rto crdy
        // Write 3/A5, pready tied 1
        tbl[0]  = '{1, 1, 4'h3, 8'hA5, 8'h00, 1,   1, 0, 1, 4'h3, 8'hA5, 0, 8'h00, 0, 0};
        tbl[1]  = '{0, 0, 4'h0, 8'h00, 8'h00, 1,   1, 1, 1, 4'h3, 8'hA5, 0, 8'h00, 0, 0};
        tbl[2]  = '{0, 0, 4'h0, 8'h00, 8'h00, 1,   0, 0, 1, 4'h3, 8'hA5, 1, 8'h00, 0, 1};
        tbl[3]  = '{0, 0, 4'h0, 8'h00, 8'h00, 1,   0, 0, 1, 4'h3, 8'hA5, 0, 8'h00, 0, 1};
        // Read 7 with two wait states, prdata 37 on the completing edge
        tbl[4]  = '{1, 0, 4'h7, 8'h00, 8'h00, 0,   1, 0, 0, 4'h7, 8'h00, 0, 8'h00, 0, 0};
        tbl[5]  = '{0, 0, 4'h0, 8'h00, 8'h00, 0,   1, 1, 0, 4'h7, 8'h00, 0, 8'h00, 0, 0};
        tbl[6]  = '{0, 0, 4'h0, 8'h00, 8'h00, 0,   1, 1, 0, 4'h7, 8'h00, 0, 8'h00, 0, 0};
        tbl[7]  = '{0, 0, 4'h0, 8'h00, 8'h00, 0,   1, 1, 0, 4'h7, 8'h00, 0, 8'h00, 0, 0};
        tbl[8]  = '{0, 0, 4'h0, 8'h00, 8'h37, 1,   0, 0, 0, 4'h7, 8'h00, 1, 8'h37, 0, 1};
        tbl[9]  = '{0, 0, 4'h0, 8'h00, 8'h00, 1,   0, 0, 0, 4'h7, 8'h00, 0, 8'h37, 0, 1};
        // Back-to-back: write 1/11 then read 2 with cmd_valid held
        tbl[10] = '{1, 1, 4'h1, 8'h11, 8'h00, 1,   1, 0, 1, 4'h1, 8'h11, 0, 8'h37, 0, 0};
        tbl[11] = '{1, 0, 4'h2, 8'h00, 8'h00, 1,   1, 1, 1, 4'h1, 8'h11, 0, 8'h37, 0, 0};
        tbl[12] = '{1, 0, 4'h2, 8'h00, 8'h00, 1,   0, 0, 1, 4'h1, 8'h11, 1, 8'h00, 0, 1};
        tbl[13] = '{1, 0, 4'h2, 8'h00, 8'h00, 1,   1, 0, 0, 4'h2, 8'h00, 0, 8'h00, 0, 0};
        tbl[14] = '{0, 0, 4'h0, 8'h00, 8'h5C, 1,   1, 1, 0, 4'h2, 8'h00, 0, 8'h00, 0, 0};
        tbl[15] = '{0, 0, 4'h0, 8'h00, 8'h5C, 1,   0, 0, 0, 4'h2, 8'h00, 1, 8'h5C, 0, 1};
        // Read 9 with pready high during SETUP: SETUP still lasts one cycle
        tbl[16] = '{1, 0, 4'h9, 8'h00, 8'h00, 1,   1, 0, 0, 4'h9, 8'h00, 0, 8'h5C, 0, 0};
        tbl[17] = '{0, 0, 4'h0, 8'h00, 8'h00, 1,   1, 1, 0, 4'h9, 8'h00, 0, 8'h5C, 0, 0};
        tbl[18] = '{0, 0, 4'h0, 8'h00, 8'hC3, 1,   0, 0, 0, 4'h9, 8'h00, 1, 8'hC3, 0, 1};
        tbl[19] = '{0, 0, 4'h0, 8'h00, 8'h00, 1,   0, 0, 0, 4'h9, 8'h00, 0, 8'hC3, 0, 1};

        rst_n = 1'b0;
        drive(0, 0, 4'h0, 8'h00, 8'h00, 0);
        #12;
        chk("reset_state", outs(), {6'd0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});
        @(negedge pclk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].cv, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].prd, tbl[i].prdy);
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {6'd0, tbl[i].e_psel, tbl[i].e_pen, tbl[i].e_pwr, tbl[i].e_paddr, tbl[i].e_pwdata,
                 tbl[i].e_rv, tbl[i].e_rdata, tbl[i].e_rto, tbl[i].e_crdy});
        end

        // Timeout: read with pready held low; penable must last exactly 15 cycles.
        drive(1, 0, 4'h5, 8'h00, 8'hEE, 0);
        tick();
        drive(0, 0, 4'h0, 8'h00, 8'hEE, 0);
        chk("to_setup", {penable, psel}, 2'b01);
        pen_cnt = 0;
        guard   = 0;
        tick();
        while (psel && guard < 40) begin
            if (penable) pen_cnt++;
            if (rsp_valid) chk("to_early_rsp", rsp_valid, 1'b0);
            guard++;
            tick();
        end
        chk("to_guard", (guard < 40), 1'b1);
        chk("to_pen_cycles", pen_cnt, 15);
        chk("to_rsp", {rsp_valid, rsp_timeout, rsp_rdata, penable}, {1'b1, 1'b1, 8'h00, 1'b0});
        tick();
        chk("to_hold", {rsp_valid, rsp_timeout, cmd_ready}, 3'b011);
        drive(1, 1, 4'h4, 8'h44, 8'h00, 1);
        tick();
        drive(0, 0, 4'h0, 8'h00, 8'h00, 1);
        tick();
        tick();
        chk("after_to_rsp", {rsp_valid, rsp_timeout, rsp_rdata, psel}, {1'b1, 1'b0, 8'h00, 1'b0});

        // Reset mid-ACCESS with pready low: APB controls drop before the next edge.
        drive(1, 0, 4'h6, 8'h00, 8'h00, 0);
        tick();
        drive(0, 0, 4'h0, 8'h00, 8'h00, 0);
        tick();
        tick();
        chk("rst_pre", {psel, penable}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {psel, penable, rsp_valid, cmd_ready}, 4'b0001);
        tick();
        tick();
        chk("rst_no_rsp", {rsp_valid, psel}, 2'b00);
        @(negedge pclk);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", cmd_ready, 1'b1);
        drive(1, 1, 4'hB, 8'h5A, 8'h00, 1);
        tick();
        drive(0, 0, 4'h0, 8'h00, 8'h00, 1);
        chk("rst_new_setup", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 4'hB, 8'h5A});
        tick();
        tick();
        chk("rst_new_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
